mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, RAM word-address width.
REQ-002 SHALL have parameter DW, default 16, RAM data width.
REQ-003 SHALL have port clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port booting  input  1  1 = bootloader owns the RAM exclusively.
REQ-006 SHALL have port boot_we / boot_addr / boot_wdata  input  1 / AW / DW  bootloader write port, no handshake.
REQ-007 SHALL have port if_req / if_addr  input  1 / AW  CPU instruction-fetch read request.
REQ-008 SHALL have port if_gnt / if_rvalid / if_rdata  output  1 / 1 / DW  fetch grant, read-data valid, read data.
REQ-009 SHALL have port d_req / d_we / d_addr / d_wdata  input  1 / 1 / AW / DW  CPU data-port request.
REQ-010 SHALL have port d_gnt / d_rvalid / d_rdata  output  1 / 1 / DW  data grant, read-data valid, read data.
REQ-011 SHALL have port ram_addr / ram_we / ram_wdata  output  AW / 1 / DW  single-port RAM command.
REQ-012 SHALL have port ram_rdata  input  DW  RAM read data, valid one cycle after the read address is presented.
REQ-013 SHALL have port conflicts  output  16  count of cycles in which if_req and d_req were both pending in RUN.

Function
REQ-014 SHALL implement two states: BOOT and RUN.
REQ-015 BOOT: ram_addr=boot_addr, ram_we=boot_we, ram_wdata=boot_wdata; if_gnt=d_gnt=0.
REQ-016 BOOT->RUN on the first clock edge where booting=0; RUN->BOOT on the first edge where booting=1; state is registered, so the mode changes one cycle after booting changes.
REQ-017 RUN: at most one grant per cycle; grants SHALL be combinational from current requests and state (same-cycle gnt).
REQ-018 RUN, single requester: that requester is granted in the same cycle.
REQ-019 RUN, both requesting: round-robin; grant the port NOT granted most recently; the last-granted pointer updates only on a grant.
REQ-020 Granted port drives ram_addr (and for data, ram_we=d_we, ram_wdata=d_wdata); fetch grants always have ram_we=0.
REQ-021 No grant in RUN: ram_we=0, ram_addr holds its previous value, ram_wdata don't-care.
REQ-022 Requesters SHALL hold req/addr/data stable until gnt; a request is consumed in its gnt cycle.
REQ-023 Read latency: x_rvalid SHALL pulse exactly one cycle after a read grant (fetch, or data with d_we=0); x_rdata=ram_rdata in that cycle; writes produce no rvalid.
REQ-024 if_rdata and d_rdata SHALL both be routed from ram_rdata; contents are meaningful only with the matching rvalid.
REQ-025 A read granted in the last RUN cycle SHALL still deliver its rvalid in the following cycle, even if the state has become BOOT.
REQ-026 Back-to-back grants allowed every cycle; sustained throughput one access per clock.
REQ-027 conflicts SHALL increment by 1 in each RUN cycle with if_req=d_req=1, and saturate at 16'hFFFF.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=BOOT, last-granted pointer=data (fetch wins first conflict), if_rvalid=d_rvalid=0, conflicts=0, ram_we=0 (in BOOT driven by boot_we), ram_addr=0.
REQ-029 Reset asserted mid-read SHALL cancel the pending rvalid; no rvalid pulse after reset release.

Verification
REQ-030 Boot: booting=1, writes 0x0001..0x0004 to addresses 0..3, if_req=1 -> ram_we follows boot_we, if_gnt=0 throughout; reading back in RUN returns 0x0001..0x0004.
REQ-031 Handoff: booting 1->0 at cycle N with if_req=1 addr 0 -> if_gnt=1 at cycle N+1, if_rvalid=1 at N+2 with if_rdata=0x0001.
REQ-032 Contention: both ports request reads continuously from reset for 6 cycles -> grants alternate if, d, if, d, if, d; conflicts=6.
REQ-033 Data write then fetch: d_req/d_we=1 addr 5 data 0xBEEF, then if_req addr 5 -> no d_rvalid; if_rvalid next cycle with 0xBEEF.
REQ-034 Mode switch mid-read: read granted in cycle N, booting=1 in cycle N -> rvalid still pulses at N+1; no grants in BOOT.
REQ-035 Async reset: rst_n pulled low between edges during a pending read -> outputs cleared immediately, no rvalid after release, conflicts=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter: shares one single-port RAM among bootloader, fetch and data ports
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          booting,
  input  logic          boot_we,
  input  logic [AW-1:0] boot_addr,
  input  logic [DW-1:0] boot_wdata,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   conflicts
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;   // 1: data port was granted most recently
  logic          if_rvalid_q, if_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [15:0]   conflicts_q, conflicts_d;
  logic [AW-1:0] addr_q, addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      last_d_q    <= 1'b1;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      conflicts_q <= 16'd0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      conflicts_q <= conflicts_d;
      addr_q      <= addr_d;
    end
  end

  always_comb begin
    state_d     = booting ? ST_BOOT : ST_RUN;
    last_d_d    = last_d_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    conflicts_d = conflicts_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_q;
    ram_wdata   = d_wdata;

    if (state_q == ST_BOOT) begin
      ram_addr  = boot_addr;
      ram_we    = boot_we;
      ram_wdata = boot_wdata;
    end else begin
      // On contention the port that lost last time wins now.
      if (if_req && (!d_req || last_d_q)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end

      if (if_gnt) begin
        ram_addr    = if_addr;
        last_d_d    = 1'b0;
        if_rvalid_d = 1'b1;
      end else if (d_gnt) begin
        ram_addr   = d_addr;
        ram_we     = d_we;
        last_d_d   = 1'b1;
        d_rvalid_d = ~d_we;
      end

      if (if_req && d_req && (conflicts_q != 16'hFFFF)) begin
        conflicts_d = conflicts_q + 16'd1;
      end
    end

    addr_d = ram_addr;
  end

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = ram_rdata;
  assign d_rdata   = ram_rdata;
  assign conflicts = conflicts_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter: directed + randomized bench with a cycle-level reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          booting;
  logic          boot_we;
  logic [AW-1:0] boot_addr;
  logic [DW-1:0] boot_wdata;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [15:0]   conflicts;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .booting(booting),
    .boot_we(boot_we), .boot_addr(boot_addr), .boot_wdata(boot_wdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflicts(conflicts)
  );

  // Environment RAM: synchronous single-port, one cycle read latency.
  logic [DW-1:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: what the outputs must be this cycle, then what happens at the edge.
  bit            m_run;
  bit            m_turn_if;          // fetch wins the next contention
  bit            m_pend_if, m_pend_d;
  logic [DW-1:0] m_if_data, m_d_data;
  int            m_conf;
  logic [AW-1:0] m_hold;
  logic [DW-1:0] m_mem [1024];
  bit            m_gi_last, m_gd_last;

  always @(negedge clk) begin
    bit            gi, gd, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    if (!rst_n) begin
      m_run = 0; m_turn_if = 1; m_pend_if = 0; m_pend_d = 0; m_conf = 0; m_hold = '0;
      m_gi_last = 0; m_gd_last = 0;
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_conflicts", conflicts, 0);
      chk("rst_ram_we", ram_we, boot_we);
    end else begin
      gi = 0; gd = 0;
      if (m_run) begin
        if (if_req && d_req) begin
          gi = m_turn_if;
          gd = !m_turn_if;
        end else begin
          gi = if_req;
          gd = d_req;
        end
      end
      we   = m_run ? (gd && d_we) : boot_we;
      addr = !m_run ? boot_addr : gi ? if_addr : gd ? d_addr : m_hold;
      wd   = m_run ? d_wdata : boot_wdata;
      chk("m_if_gnt", if_gnt, gi);
      chk("m_d_gnt", d_gnt, gd);
      chk("m_ram_we", ram_we, we);
      chk("m_ram_addr", ram_addr, addr);
      if (we) chk("m_ram_wdata", ram_wdata, wd);
      chk("m_if_rvalid", if_rvalid, m_pend_if);
      chk("m_d_rvalid", d_rvalid, m_pend_d);
      if (m_pend_if) chk("m_if_rdata", if_rdata, m_if_data);
      if (m_pend_d) chk("m_d_rdata", d_rdata, m_d_data);
      chk("m_conflicts", conflicts, m_conf);

      m_pend_if = gi;
      m_if_data = m_mem[if_addr];
      m_pend_d  = gd && !d_we;
      m_d_data  = m_mem[d_addr];
      if (we) m_mem[addr] = wd;
      if (gi) m_turn_if = 0;
      if (gd) m_turn_if = 1;
      if (m_run && if_req && d_req && m_conf < 65535) m_conf++;
      m_hold = addr;
      m_run  = !booting;
      m_gi_last = gi;
      m_gd_last = gd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    rst_n = 0; booting = 1; boot_we = 0; boot_addr = '0; boot_wdata = '0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_conflicts", conflicts, 0);
    chk("reset_ram_addr", ram_addr, 0);
    step();
    rst_n = 1;
    if_req = 1;

    // Bootloader writes 1..4 to addresses 0..3 while fetch is locked out.
    for (int a = 0; a < 4; a++) begin
      step();
      boot_we = 1; boot_addr = AW'(a); boot_wdata = DW'(a + 1);
      @(negedge clk);
      chk("boot_if_gnt", if_gnt, 0);
      chk("boot_ram_we", ram_we, 1);
      chk("boot_ram_addr", ram_addr, a);
    end

    // Handoff: booting drops, grant follows one cycle later.
    step();
    boot_we = 0; booting = 0;
    @(negedge clk);
    chk("handoff_no_gnt_yet", if_gnt, 0);
    step();
    @(negedge clk);
    chk("handoff_if_gnt", if_gnt, 1);
    for (int a = 1; a <= 4; a++) begin
      step();
      if (a < 4) if_addr = AW'(a); else if_req = 0;
      @(negedge clk);
      chk("readback_rvalid", if_rvalid, 1);
      chk("readback_rdata", if_rdata, a);
    end

    // Data write then fetch of the same word.
    step();
    d_req = 1; d_we = 1; d_addr = 10'd5; d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("dwr_d_gnt", d_gnt, 1);
    chk("dwr_ram_we", ram_we, 1);
    step();
    d_req = 0; d_we = 0; if_req = 1; if_addr = 10'd5;
    @(negedge clk);
    chk("dwr_no_d_rvalid", d_rvalid, 0);
    chk("dwr_if_gnt", if_gnt, 1);
    step();
    booting = 1;
    @(negedge clk);
    chk("dwr_if_rvalid", if_rvalid, 1);
    chk("dwr_if_rdata", if_rdata, 16'hBEEF);
    chk("switch_if_gnt", if_gnt, 1);

    // The read granted in the last RUN cycle still completes in BOOT.
    step();
    @(negedge clk);
    chk("switch_rvalid", if_rvalid, 1);
    chk("switch_rdata", if_rdata, 16'hBEEF);
    chk("switch_no_gnt", if_gnt, 0);
    step();
    @(negedge clk);
    chk("switch_rvalid_done", if_rvalid, 0);
    chk("switch_no_gnt2", if_gnt, 0);

    // Randomized traffic; requests held until granted.
    for (int c = 0; c < 2000; c++) begin
      step();
      if (!if_req || m_gi_last) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = AW'($urandom_range(0, 15));
      end
      if (!d_req || m_gd_last) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = AW'($urandom_range(0, 15));
        d_wdata = DW'($urandom);
      end
      if ($urandom_range(0, 29) == 0) booting = !booting;
      boot_we    = $urandom_range(0, 1) == 1;
      boot_addr  = AW'($urandom_range(0, 15));
      boot_wdata = DW'($urandom);
    end

    // Contention from reset: strict alternation starting with fetch.
    step();
    boot_we = 0; booting = 0; rst_n = 0;
    if_req = 1; if_addr = 10'd1; d_req = 1; d_we = 0; d_addr = 10'd2;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("rr_boot_no_gnt", if_gnt | d_gnt, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk("rr_if_gnt", if_gnt, (k % 2) == 0);
      chk("rr_d_gnt", d_gnt, (k % 2) == 1);
    end
    step();
    @(negedge clk);
    chk("rr_conflicts6", conflicts, 6);

    // Keep contending until the counter saturates.
    repeat (65540) step();
    @(negedge clk);
    chk("conflicts_saturated", conflicts, 16'hFFFF);

    // Async reset while a fetch read is in flight.
    step();
    d_req = 0;
    @(negedge clk);
    chk("async_pre_gnt", if_gnt, 1);
    step();
    #1;
    rst_n = 0;
    #1;
    chk("async_rvalid_cleared", if_rvalid, 0);
    chk("async_conflicts_cleared", conflicts, 0);
    chk("async_ram_addr", ram_addr, boot_addr);
    if_req = 0;
    step();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("async_no_rvalid", if_rvalid | d_rvalid, 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
